// File: rtl/ov5640_cfg_seq.sv
// OV5640 configuration sequencer: power-up wait, then one SCCB write per ROM entry with NACK retry.
// Latency: first i2c_start POWER_WAIT+2 cycles after reset; 4 cycles from an ACKed i2c_end to the next start.
// Backpressure: one transfer outstanding at a time; the FSM stalls in WAIT_WR/WAIT_RD until i2c_end.
// Optional feature: define OV5640_CFG_VERIFY_EN to read back and compare every write (except 16'h3008).
module ov5640_cfg_seq #(
   parameter logic [7:0]  REG_NUM    = 8'd251,
   parameter logic [14:0] POWER_WAIT = 15'd20000,
   parameter logic [1:0]  MAX_RETRY  = 2'd3
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cfg_restart,
   output logic [7:0]  cfg_idx,
   input  logic [23:0] cfg_word,
   output logic        i2c_start,
   output logic        i2c_wr_rd,
   output logic [15:0] i2c_addr,
   output logic [7:0]  i2c_wdata,
   input  logic        i2c_end,
   input  logic        i2c_ack_err,
   input  logic [7:0]  i2c_rdata,
   output logic        cfg_done,
   output logic        cfg_err
);

   // Software-reset register clears itself, so reading it back is meaningless.
   localparam logic [15:0] SW_RST_ADDR = 16'h3008;

`ifdef OV5640_CFG_VERIFY_EN
   typedef enum logic [3:0] {
      S_WAIT_PWR, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_WR,
      S_ISSUE_RD, S_WAIT_RD, S_NEXT, S_DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_WAIT_PWR, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_WR,
      S_NEXT, S_DONE
   } state_t;
`endif

   state_t        r_state;
   state_t        w_next;
   logic [14:0]   r_pwr_cnt;
   logic [7:0]    r_idx;
   logic [1:0]    r_attempt;
   logic [15:0]   r_addr;
   logic [7:0]    r_wdata;
   logic          r_err;

   logic          w_pwr_last;
   logic          w_last_entry;
   logic [2:0]    w_attempt_inc;
   logic          w_retry_ok;
   logic          w_wr_ok;
   logic          w_fail;
   logic          w_restart;

   // Power-wait ends on the POWER_WAIT-th cycle spent in WAIT_PWR (widened so POWER_WAIT=0 is safe).
   assign w_pwr_last    = ({1'b0, r_pwr_cnt} + 16'd1) >= {1'b0, POWER_WAIT};
   assign w_last_entry  = (r_idx == (REG_NUM - 8'd1));
   assign w_attempt_inc = {1'b0, r_attempt} + 3'd1;
   assign w_retry_ok    = (w_attempt_inc < {1'b0, MAX_RETRY});
   assign w_wr_ok       = (r_state == S_WAIT_WR) && i2c_end && !i2c_ack_err;
   assign w_restart     = (r_state == S_DONE) && cfg_restart;

`ifdef OV5640_CFG_VERIFY_EN
   logic w_rd_fail;
   // A read-back counts as failed on NACK or on data that differs from what was written.
   assign w_rd_fail = (r_state == S_WAIT_RD) && i2c_end && (i2c_ack_err || (i2c_rdata != r_wdata));
   assign w_fail    = ((r_state == S_WAIT_WR) && i2c_end && i2c_ack_err) || w_rd_fail;
`else
   logic w_unused_rdata;
   assign w_unused_rdata = ^i2c_rdata;
   assign w_fail         = (r_state == S_WAIT_WR) && i2c_end && i2c_ack_err;
`endif

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_WAIT_PWR;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: walk the table, retrying failed attempts until MAX_RETRY is used up.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_WAIT_PWR: if (w_pwr_last) w_next = S_FETCH;
         S_FETCH:    w_next = S_LATCH;
         S_LATCH:    w_next = S_ISSUE;
         S_ISSUE:    w_next = S_WAIT_WR;
         S_WAIT_WR: begin
            if (w_wr_ok) begin
`ifdef OV5640_CFG_VERIFY_EN
               w_next = (r_addr == SW_RST_ADDR) ? S_NEXT : S_ISSUE_RD;
`else
               w_next = S_NEXT;
`endif
            end else if (w_fail) begin
               w_next = w_retry_ok ? S_ISSUE : S_NEXT;
            end
         end
`ifdef OV5640_CFG_VERIFY_EN
         S_ISSUE_RD: w_next = S_WAIT_RD;
         S_WAIT_RD: begin
            if (w_fail) begin
               w_next = w_retry_ok ? S_ISSUE : S_NEXT;
            end else if (i2c_end) begin
               w_next = S_NEXT;
            end
         end
`endif
         S_NEXT:     w_next = w_last_entry ? S_DONE : S_FETCH;
         S_DONE:     if (cfg_restart) w_next = S_FETCH;
         default:    w_next = S_WAIT_PWR;
      endcase
   end

   // Output decode: start is a one-cycle pulse from the ISSUE states; direction is held through the wait.
   always_comb begin
      i2c_start = 1'b0;
      i2c_wr_rd = 1'b0;
      cfg_done  = 1'b0;
      case (r_state)
         S_ISSUE:    i2c_start = 1'b1;
`ifdef OV5640_CFG_VERIFY_EN
         S_ISSUE_RD: begin
            i2c_start = 1'b1;
            i2c_wr_rd = 1'b1;
         end
         S_WAIT_RD:  i2c_wr_rd = 1'b1;
`endif
         S_DONE:     cfg_done = 1'b1;
         default:    ;
      endcase
   end

   // Power-up counter; only meaningful in WAIT_PWR, which is re-entered only through reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_pwr_cnt <= 15'd0;
      end else if (r_state == S_WAIT_PWR) begin
         r_pwr_cnt <= r_pwr_cnt + 15'd1;
      end
   end

   // Table index, attempt counter and sticky error.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_idx     <= 8'd0;
         r_attempt <= 2'd0;
         r_err     <= 1'b0;
      end else if (w_restart) begin
         r_idx     <= 8'd0;
         r_attempt <= 2'd0;
         r_err     <= 1'b0;
      end else if (r_state == S_NEXT) begin
         r_attempt <= 2'd0;
         if (!w_last_entry) r_idx <= r_idx + 8'd1;
      end else if (w_fail) begin
         r_attempt <= w_attempt_inc[1:0];
         if (!w_retry_ok) r_err <= 1'b1;
      end
   end

   // Capture the ROM word once it has settled; held unchanged until the entry is finished.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_addr  <= 16'd0;
         r_wdata <= 8'd0;
      end else if (r_state == S_LATCH) begin
         r_addr  <= cfg_word[23:8];
         r_wdata <= cfg_word[7:0];
      end
   end

   assign cfg_idx   = r_idx;
   assign i2c_addr  = r_addr;
   assign i2c_wdata = r_wdata;
   assign cfg_err   = r_err;

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Bench for ov5640_cfg_seq: 3-entry ROM, 100-cycle power wait, I2C master model ending 10 cycles after start.
// Directed scenarios with hand-computed start cycles; cycle 0 is the cycle in which reset is released.
// Define OV5640_CFG_VERIFY_EN for both RTL and bench to exercise the read-back variant.
module tb_ov5640_cfg_seq;
   localparam int LAT = 10;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        cfg_restart;
   logic [7:0]  cfg_idx;
   logic [23:0] cfg_word;
   logic        i2c_start;
   logic        i2c_wr_rd;
   logic [15:0] i2c_addr;
   logic [7:0]  i2c_wdata;
   logic        i2c_end;
   logic        i2c_ack_err;
   logic [7:0]  i2c_rdata;
   logic        cfg_done;
   logic        cfg_err;

   int checks = 0;
   int errors = 0;
   int cyc;

   logic [23:0] rom [4];
   int          st_cyc [$];
   logic [15:0] st_addr [$];
   logic [7:0]  st_data [$];
   logic        st_wr [$];
   logic [7:0]  st_idx [$];
   int          overlap = 0;
   logic [15:0] nack_addr = 16'hFFFF;
   int          nack_left = 0;
   int          rd_bad_left = 0;

   ov5640_cfg_seq #(
      .REG_NUM    (8'd3),
      .POWER_WAIT (15'd100),
      .MAX_RETRY  (2'd3)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .cfg_restart (cfg_restart),
      .cfg_idx     (cfg_idx),
      .cfg_word    (cfg_word),
      .i2c_start   (i2c_start),
      .i2c_wr_rd   (i2c_wr_rd),
      .i2c_addr    (i2c_addr),
      .i2c_wdata   (i2c_wdata),
      .i2c_end     (i2c_end),
      .i2c_ack_err (i2c_ack_err),
      .i2c_rdata   (i2c_rdata),
      .cfg_done    (cfg_done),
      .cfg_err     (cfg_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Register ROM with one cycle of read latency.
   always @(posedge sys_clk) cfg_word <= rom[cfg_idx[1:0]];

   // Cycle counter: 0 during reset and in the release cycle.
   always @(posedge sys_clk) begin
      if (!sys_rst_n) cyc <= 0;
      else            cyc <= cyc + 1;
   end

   // I2C master model: records each start, answers with i2c_end LAT cycles later.
   initial begin
      int          cnt;
      logic        busy;
      logic        cur_wr;
      logic [15:0] cur_addr;
      logic [7:0]  last_wdata;
      cnt = 0; busy = 1'b0; cur_wr = 1'b0; cur_addr = 16'h0; last_wdata = 8'h0;
      i2c_end = 1'b0; i2c_ack_err = 1'b0; i2c_rdata = 8'h0;
      forever begin
         @(negedge sys_clk);
         i2c_end = 1'b0; i2c_ack_err = 1'b0; i2c_rdata = 8'h0;
         if (!sys_rst_n) begin
            busy = 1'b0;
         end else if (i2c_start === 1'b1) begin
            if (busy) overlap++;
            st_cyc.push_back(cyc);
            st_addr.push_back(i2c_addr);
            st_data.push_back(i2c_wdata);
            st_wr.push_back(i2c_wr_rd);
            st_idx.push_back(cfg_idx);
            busy = 1'b1; cnt = LAT; cur_wr = i2c_wr_rd; cur_addr = i2c_addr;
            if (!i2c_wr_rd) last_wdata = i2c_wdata;
         end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
               busy = 1'b0;
               i2c_end = 1'b1;
               if (!cur_wr) begin
                  if (cur_addr == nack_addr && nack_left > 0) begin
                     i2c_ack_err = 1'b1;
                     nack_left--;
                  end
               end else if (rd_bad_left > 0) begin
                  i2c_rdata = 8'h00;
                  rd_bad_left--;
               end else begin
                  i2c_rdata = last_wdata;
               end
            end
         end
      end
   end

   task automatic clear_log;
      st_cyc.delete(); st_addr.delete(); st_data.delete(); st_wr.delete(); st_idx.delete();
   endtask

   task automatic apply_reset;
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      clear_log();
      sys_rst_n = 1'b1;
   endtask

   task automatic wait_done(input int budget, output bit ok, output int done_c);
      int n;
      ok = 1'b0; done_c = -1; n = 0;
      while (!ok && n < budget) begin
         @(negedge sys_clk);
         n++;
         if (cfg_done === 1'b1) begin
            ok = 1'b1;
            done_c = cyc;
         end
      end
   endtask

   task automatic test_reset;
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      checks++;
      if ({cfg_idx, i2c_start, i2c_wr_rd, i2c_addr, i2c_wdata, cfg_done, cfg_err} !== 36'd0) begin
         errors++;
         $display("FAIL reset_outputs got idx=%h st=%b wr=%b addr=%h dat=%h done=%b err=%b want all 0",
                  cfg_idx, i2c_start, i2c_wr_rd, i2c_addr, i2c_wdata, cfg_done, cfg_err);
      end
   endtask

   // Compare the start log against expected cycles and entry numbers (all writes).
   task automatic check_log(input string name, input int n, input int exp_c [7], input int exp_e [7]);
      checks++;
      if (st_cyc.size() != n) begin
         errors++;
         $display("FAIL %s_start_count got %0d want %0d", name, st_cyc.size(), n);
      end
      for (int i = 0; i < n && i < st_cyc.size(); i++) begin
         checks++;
         if (st_cyc[i] != exp_c[i] || st_addr[i] !== rom[exp_e[i]][23:8] ||
             st_data[i] !== rom[exp_e[i]][7:0] || st_wr[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s_start%0d got cyc=%0d addr=%h dat=%h wr=%b want cyc=%0d addr=%h dat=%h wr=0",
                     name, i, st_cyc[i], st_addr[i], st_data[i], st_wr[i],
                     exp_c[i], rom[exp_e[i]][23:8], rom[exp_e[i]][7:0]);
         end
      end
   endtask

   task automatic test_power_up;
      bit ok; int dc;
      nack_left = 0;
      apply_reset();
      wait_done(1000, ok, dc);
      checks++;
      if (!ok || dc != 142) begin
         errors++;
         $display("FAIL pwr_done_cycle got %0d (seen=%0b) want 142", dc, ok);
      end
      check_log("pwr", 3, '{102, 116, 130, 0, 0, 0, 0}, '{0, 1, 2, 0, 0, 0, 0});
      checks++;
      if (cfg_err !== 1'b0 || cfg_idx !== 8'd2) begin
         errors++;
         $display("FAIL pwr_final got err=%b idx=%0d want err=0 idx=2", cfg_err, cfg_idx);
      end
   endtask

   task automatic test_single_nack;
      bit ok; int dc;
      apply_reset();
      nack_addr = rom[1][23:8];
      nack_left = 1;
      wait_done(1000, ok, dc);
      checks++;
      if (!ok || dc != 153) begin
         errors++;
         $display("FAIL nack1_done_cycle got %0d (seen=%0b) want 153", dc, ok);
      end
      check_log("nack1", 4, '{102, 116, 127, 141, 0, 0, 0}, '{0, 1, 1, 2, 0, 0, 0});
      checks++;
      if (st_idx.size() != 4 || st_idx[2] !== 8'd1 || st_idx[3] !== 8'd2) begin
         errors++;
         $display("FAIL nack1_idx got n=%0d retry_idx=%0d next_idx=%0d want 4/1/2",
                  st_idx.size(), (st_idx.size() > 2) ? st_idx[2] : 8'hFF, (st_idx.size() > 3) ? st_idx[3] : 8'hFF);
      end
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL nack1_err got %b want 0", cfg_err);
      end
   endtask

   task automatic test_persistent_nack;
      bit ok; int dc;
      apply_reset();
      nack_addr = rom[0][23:8];
      nack_left = 100;
      wait_done(1000, ok, dc);
      nack_left = 0;
      checks++;
      if (!ok || dc != 164) begin
         errors++;
         $display("FAIL nackall_done_cycle got %0d (seen=%0b) want 164", dc, ok);
      end
      check_log("nackall", 5, '{102, 113, 124, 138, 152, 0, 0}, '{0, 0, 0, 1, 2, 0, 0});
      checks++;
      if (cfg_err !== 1'b1 || cfg_done !== 1'b1) begin
         errors++;
         $display("FAIL nackall_flags got err=%b done=%b want err=1 done=1", cfg_err, cfg_done);
      end
   endtask

   // Entered in DONE with cfg_err=1 from the previous scenario.
   task automatic test_restart;
      bit ok; int dc; int c; int n;
      clear_log();
      @(negedge sys_clk);
      c = cyc;
      cfg_restart = 1'b1;
      @(negedge sys_clk);
      cfg_restart = 1'b0;
      checks++;
      if (cfg_done !== 1'b0 || cfg_err !== 1'b0 || cfg_idx !== 8'd0) begin
         errors++;
         $display("FAIL restart_clear got done=%b err=%b idx=%0d want 0/0/0", cfg_done, cfg_err, cfg_idx);
      end
      n = 0;
      while (cyc < c + 6 && n < 50) begin
         @(negedge sys_clk);
         n++;
      end
      // Pulse during WAIT_WR of entry 0: must be ignored.
      cfg_restart = 1'b1;
      @(negedge sys_clk);
      cfg_restart = 1'b0;
      wait_done(1000, ok, dc);
      checks++;
      if (!ok || dc != c + 43) begin
         errors++;
         $display("FAIL restart_done_cycle got %0d (seen=%0b) want %0d", dc, ok, c + 43);
      end
      check_log("restart", 3, '{c + 3, c + 17, c + 31, 0, 0, 0, 0}, '{0, 1, 2, 0, 0, 0, 0});
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL restart_err got %b want 0", cfg_err);
      end
   endtask

   task automatic test_reset_mid;
      bit ok; int dc; int n;
      apply_reset();
      n = 0;
      while (st_cyc.size() < 3 && n < 500) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (st_cyc.size() < 3) begin
         errors++;
         $display("FAIL rstmid_reach_entry2 got %0d starts want 3", st_cyc.size());
      end
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if ({cfg_idx, i2c_start, i2c_wr_rd, i2c_addr, i2c_wdata, cfg_done, cfg_err} !== 36'd0) begin
         errors++;
         $display("FAIL rstmid_outputs got idx=%h st=%b addr=%h dat=%h done=%b err=%b want all 0",
                  cfg_idx, i2c_start, i2c_addr, i2c_wdata, cfg_done, cfg_err);
      end
      repeat (3) @(negedge sys_clk);
      clear_log();
      sys_rst_n = 1'b1;
      wait_done(1000, ok, dc);
      checks++;
      if (!ok || dc != 142) begin
         errors++;
         $display("FAIL rstmid_done_cycle got %0d (seen=%0b) want 142", dc, ok);
      end
      check_log("rstmid", 3, '{102, 116, 130, 0, 0, 0, 0}, '{0, 1, 2, 0, 0, 0, 0});
   endtask

`ifdef OV5640_CFG_VERIFY_EN
   task automatic test_verify;
      bit ok; int dc;
      int   exp_c [7] = '{102, 113, 124, 135, 149, 163, 174};
      int   exp_e [7] = '{0, 0, 0, 0, 1, 2, 2};
      logic exp_w [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      apply_reset();
      nack_left = 0;
      rd_bad_left = 1;
      wait_done(1000, ok, dc);
      checks++;
      if (!ok || dc != 186) begin
         errors++;
         $display("FAIL verify_done_cycle got %0d (seen=%0b) want 186", dc, ok);
      end
      checks++;
      if (st_cyc.size() != 7) begin
         errors++;
         $display("FAIL verify_start_count got %0d want 7", st_cyc.size());
      end
      for (int i = 0; i < 7 && i < st_cyc.size(); i++) begin
         checks++;
         if (st_cyc[i] != exp_c[i] || st_addr[i] !== rom[exp_e[i]][23:8] ||
             st_data[i] !== rom[exp_e[i]][7:0] || st_wr[i] !== exp_w[i]) begin
            errors++;
            $display("FAIL verify_start%0d got cyc=%0d addr=%h dat=%h wr=%b want cyc=%0d addr=%h dat=%h wr=%b",
                     i, st_cyc[i], st_addr[i], st_data[i], st_wr[i],
                     exp_c[i], rom[exp_e[i]][23:8], rom[exp_e[i]][7:0], exp_w[i]);
         end
      end
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL verify_err got %b want 0", cfg_err);
      end
   endtask
`endif

   task automatic test_handshake;
      checks++;
      if (overlap != 0) begin
         errors++;
         $display("FAIL start_while_busy got %0d want 0", overlap);
      end
   endtask

   initial begin
      rom[0] = {16'h3103, 8'h5A};
      rom[1] = {16'h3008, 8'h82};
      rom[2] = {16'h3017, 8'hFF};
      rom[3] = 24'h0;
      sys_rst_n = 1'b0;
      cfg_restart = 1'b0;
      test_reset();
`ifdef OV5640_CFG_VERIFY_EN
      test_verify();
`else
      test_power_up();
      test_single_nack();
      test_persistent_nack();
      test_restart();
      test_reset_mid();
`endif
      test_handshake();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
